// File: rtl/gpr_file_sb_pkg.sv
// Shared types and helpers for the gpr_file_sb register file slice.
package gpr_pkg;

    // Clear-engine states
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } gpr_state_e;

    // Register count for a given address width
    function automatic int gpr_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    // LSB of port k inside a flattened multi-port bus of per-port width w
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/gpr_file_sb_if.sv
// Decode/writeback-facing bus of gpr_file_sb; master drives, slave is the file.
interface gpr_file_sb_if
    import gpr_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int N_RD   = 2
);
    localparam int DEPTH = gpr_depth(ADDR_W);

    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [N_RD*ADDR_W-1:0]   rd_addr;
    logic [N_RD*DATA_W-1:0]   rd_data;
    logic [N_RD-1:0]          rd_busy;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic [DEPTH-1:0]         busy;
    logic                     clr_req;
    logic                     clr_busy;
    logic                     clr_done;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr, clr_req,
        input  rd_data, rd_busy, busy, clr_busy, clr_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr, clr_req,
        output rd_data, rd_busy, busy, clr_busy, clr_done
    );
endinterface

// File: rtl/gpr_file_sb_scoreboard.sv
// Pending-write bitmap: set on issue, cleared on writeback, wiped on clear start.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int N_RD   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   set_en,
    input  logic [ADDR_W-1:0]      set_addr,
    input  logic                   clr_en,
    input  logic [ADDR_W-1:0]      clr_addr,
    input  logic                   clr_all,
    input  logic [N_RD*ADDR_W-1:0] rd_addr,
    output logic [2**ADDR_W-1:0]   busy,
    output logic [N_RD-1:0]        rd_busy
);

    // Clear-all dominates; otherwise issue (set) wins over writeback (clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (clr_all) begin
            busy <= '0;
        end else begin
            if (clr_en) busy[clr_addr] <= 1'b0;
            if (set_en) busy[set_addr] <= 1'b1;
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        assign rd_busy[k] = busy[rd_addr[port_lsb(k, ADDR_W) +: ADDR_W]];
    end

endmodule

// File: rtl/gpr_file_sb.sv
// Parametrised GPR file with async reset, pending-write scoreboard and a
// sequenced clear engine. Optional macro GPR_FILE_BYPASS_EN forwards the
// writeback data to same-cycle reads.
module gpr_file_sb
    import gpr_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int N_RD    = 2,
    parameter int ZERO_R0 = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    gpr_file_sb_if.slave  bus
);
    localparam int DEPTH = gpr_depth(ADDR_W);

    logic [DATA_W-1:0] regs [DEPTH];
    gpr_state_e        state;
    logic [ADDR_W-1:0] cnt;
    logic              clr_busy_q;
    logic              clr_done_q;

    logic idle, wr_ok, iss_ok;
    assign idle   = (state == IDLE);
    // r0 is hardwired when ZERO_R0 is set, so its writes/issues are dropped here
    assign wr_ok  = idle && bus.wr_en  && !(ZERO_R0 != 0 && bus.wr_addr  == '0);
    assign iss_ok = idle && bus.iss_en && !(ZERO_R0 != 0 && bus.iss_addr == '0);

    // Storage: clear engine owns the array while in CLEAR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (state == CLEAR) begin
            regs[cnt] <= '0;
        end else if (wr_ok) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Clear FSM: walks cnt 0..DEPTH-1, pulses done in the first IDLE cycle after
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clr_done_q <= 1'b0;
                    if (bus.clr_req) begin
                        state      <= CLEAR;
                        cnt        <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state      <= IDLE;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.clr_busy = clr_busy_q;
    assign bus.clr_done = clr_done_q;

    logic [N_RD-1:0] sb_rd_busy;

    gpr_scoreboard #(.ADDR_W(ADDR_W), .N_RD(N_RD)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (iss_ok),
        .set_addr (bus.iss_addr),
        .clr_en   (wr_ok),
        .clr_addr (bus.wr_addr),
        .clr_all  (idle && bus.clr_req),
        .rd_addr  (bus.rd_addr),
        .busy     (bus.busy),
        .rd_busy  (sb_rd_busy)
    );

    logic [N_RD-1:0][DATA_W-1:0] rd_data_a;
    logic [N_RD-1:0]             byp;

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = bus.rd_addr[port_lsb(k, ADDR_W) +: ADDR_W];
`ifdef GPR_FILE_BYPASS_EN
        // wr_ok already excludes CLEAR and a hardwired r0
        assign byp[k] = wr_ok && (ra == bus.wr_addr);
`else
        assign byp[k] = 1'b0;
`endif
        assign rd_data_a[k] = byp[k] ? bus.wr_data
                            : ((ZERO_R0 != 0 && ra == '0) ? '0 : regs[ra]);
    end

    assign bus.rd_data = rd_data_a;
    assign bus.rd_busy = sb_rd_busy & ~byp;

endmodule

// File: doc/gpr_file_sb.md
# gpr_file_sb

Parametrised general-purpose register file for the RISC CPU datapath: configurable data width, register count and number of read ports. It adds three things the fixed 8x16 two-port file lacks: asynchronous active-low reset of all registers, a scoreboard of per-register pending-write bits for hazard detection, and a sequenced clear engine. It sits between decode (issue, reads) and writeback (write port).

## Interface
Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, register address width; DEPTH = 2**ADDR_W.
- N_RD, 2, number of read ports (1..4).
- ZERO_R0, 0, when 1: r0 always reads 0, writes to r0 are discarded, and r0 is never marked busy.

Ports:
- clk  in  1  system clock, all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write destination.
- wr_data  in  DATA_W  write data.
- rd_addr  in  N_RD*ADDR_W  read addresses; port k is at bits [k*ADDR_W +: ADDR_W].
- rd_data  out  N_RD*DATA_W  read data, same packing as rd_addr.
- rd_busy  out  N_RD  scoreboard bit of the addressed register, one bit per port.
- iss_en  in  1  marks iss_addr as pending a write.
- iss_addr  in  ADDR_W  register being issued.
- busy  out  DEPTH  full scoreboard bitmap.
- clr_req  in  1  starts the clear sequence; sampled only in IDLE.
- clr_busy  out  1  high while the clear sequence is running.
- clr_done  out  1  one-cycle pulse when the clear sequence finishes.

## Operation
- Reset: all registers, busy, clr_busy and clr_done go to 0 immediately. The FSM goes to IDLE. rd_data then reads 0 on every port.
- Reads are combinational: rd_data[k] = reg[rd_addr[k]].
- Write: in IDLE, when wr_en=1, reg[wr_addr] <= wr_data at the edge and busy[wr_addr] is cleared.
- Issue: in IDLE, when iss_en=1, busy[iss_addr] is set at the edge.
- Issue and write to the same address in the same cycle: data is written and busy ends at 1, because the issue wins.
- Issue and write to different addresses in the same cycle: both take effect.
- FSM states:
  - IDLE to CLEAR when clr_req=1. On that edge the counter loads 0 and all busy bits clear.
  - CLEAR: reg[cnt] <= 0 and cnt increments each cycle. wr_en and iss_en are ignored; clr_req is ignored.
  - When cnt = DEPTH-1, that register clears and the FSM returns to IDLE. clr_done pulses in the first IDLE cycle.
- The counter is ADDR_W bits wide. Its wrap is never reached because the exit happens at DEPTH-1.
- ZERO_R0=1: reg[0] is constant 0; wr_addr=0 and iss_addr=0 have no effect.

## Timing
- Read latency: 0 cycles, combinational from rd_addr.
- Write visibility without bypass: readable in the cycle after the write edge.
- busy and rd_busy reflect issues and writes from the cycle after the edge.
- Clear sequence: clr_busy is high for exactly DEPTH cycles, starting the cycle after clr_req is sampled. clr_done pulses on cycle DEPTH+1.
- rst_n asserted mid-clear aborts the sequence at once. clr_done is not pulsed.
- Reset deassertion must be synchronised to clk outside this block.

## Configuration
- GPR_FILE_BYPASS_EN defined:
  - Each read port forwards wr_data combinationally when wr_en=1, the FSM is in IDLE, and rd_addr[k] equals wr_addr (excluding r0 when ZERO_R0=1).
  - rd_busy[k] reads 0 under the same condition.
- GPR_FILE_BYPASS_EN undefined: no forwarding; reads return the stored value only.

## Structure
- A shared package gpr_pkg holds:
  - the FSM state enum: IDLE and CLEAR;
  - a localparam function for DEPTH;
  - the read-port pack/unpack helper for the flattened rd_addr and rd_data buses.
- One sub-module, gpr_scoreboard: the busy bitmap with its set, clear and clear-all logic plus the rd_busy lookup.
- The storage array, the read muxes, bypass and the clear FSM stay in gpr_file_sb.

## Test plan
- Reset and read: apply rst_n=0 while registers are nonzero -> all rd_data = 0 and busy = 0 immediately, without a clock edge.
- Write then read: write 0xBEEF to r5, then read r5 on both ports next cycle -> 0xBEEF. With bypass, the read in the same cycle also returns 0xBEEF.
- Scoreboard: issue r3 -> busy[3]=1 next cycle and rd_busy=1 on a port reading r3. Then write r3 -> busy[3]=0. Issue and write r3 in the same cycle -> busy[3]=1.
- ZERO_R0=1: write 0x1234 to r0 and issue r0 -> reads return 0 and busy[0]=0.
- Clear sequence: preload all registers with 0xFFFF and pulse clr_req -> clr_busy high for 8 cycles and clr_done pulses on cycle 9. Writes and issues during CLEAR are ignored, and all registers read 0 afterwards.
- Reset mid-clear: assert rst_n=0 on the 4th CLEAR cycle -> clr_busy=0 immediately, all registers 0, and no clr_done pulse.
